sram_match_arbiter: RTL
=======================

# sram_match_arbiter

Shared SRAM matcher between the 16 write-port frontends and the 32 packet SRAMs. It arbitrates the ports' `match_enable` requests round-robin, then scans the SRAMs starting from the requester's destination-port home slot, one SRAM per cycle. It grants the first unlocked SRAM with enough free words. A grant locks the SRAM to the port and pulses `match_end` back to that port; the lock holds until the port pulses `release` at end of packet.

## Interface
- `NUM_PORTS`, 16, number of write ports (fixed; 4-bit indices).
- `NUM_SRAMS`, 32, number of SRAMs (fixed; 5-bit indices).
- `FREE_W`, 12, width of per-SRAM free-word count (SRAM depth 2048 words).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `match_enable` in 16: per-port level request; held until that port sees `match_end`.
- `new_dest_port` in 64: port p's destination in bits [4p+3:4p].
- `new_length` in 144: port p's packet length in words in bits [9p+8:9p].
- `free_cnt` in 384: SRAM s free-word count in bits [12s+11:12s].
- `release` in 16: one-cycle pulse per port; frees that port's locked SRAM.
- `match_end` out 16: one-hot, one-cycle grant pulse to the matched port.
- `match_sram` out 5: granted SRAM index; valid while `match_end` is non-zero.
- `alloc_vld` out 1: one-cycle reservation pulse to the memory manager, coincident with `match_end`.
- `alloc_len` out 9: words to reserve; valid with `alloc_vld`.
- `sram_locked` out 32: current lock vector.

## Operation
- FSM states: IDLE, SCAN, DONE.
- **IDLE**
  - Pending vector = `match_enable` with the port granted in the immediately preceding DONE masked.
  - If pending is non-zero, pick the first set bit searching from `rr_ptr+1` upward, mod 16.
  - Capture the port index, dest (4b) and length (9b) into registers.
  - Set `scan_idx = {dest,1'b0}` and `scan_cnt = 0`; go to SCAN.
- **SCAN**, each cycle:
  - Hit if `!locked[scan_idx] && free_cnt[scan_idx] >= {3'b0,len}`, as a 12-bit unsigned compare.
  - On hit, go to DONE.
  - On miss with `scan_cnt == 31`, the match fails: go to IDLE with no output pulse and set `rr_ptr` = the failed port. The port stays pending and is retried after other requesters get a turn.
  - Otherwise `scan_idx <= scan_idx+1`, wrapping 31→0 as 5-bit arithmetic, and `scan_cnt++`.
- **DONE**, single cycle:
  - `match_end[port]=1`, `match_sram=scan_idx`, `alloc_vld=1`, `alloc_len=len`.
  - Set `locked[scan_idx]`, set `owner[port]=scan_idx` with `own_vld[port]=1`, and set `rr_ptr=port`.
  - Go to IDLE.
- **Release**
  - `release[p]` with `own_vld[p]` set clears `locked[owner[p]]` and `own_vld[p]`.
  - `release[p]` without `own_vld[p]` is ignored.
  - Multiple ports may release in the same cycle.
- **Simultaneous events**
  - Grant and release for the same port in one cycle: the grant wins. The old lock is cleared and the new lock is set.
  - A port granted while already holding a lock implicitly releases its old SRAM.
  - A release in a SCAN cycle takes effect for scan decisions from the next cycle.
  - `free_cnt` is sampled live each SCAN cycle.
- **Changing requests**
  - Requests that drop during SCAN are not aborted: the grant still issues.
  - Dest and length are sampled only in IDLE.
- **Reset**, asynchronous, at any time:
  - FSM → IDLE; `rr_ptr = 15`, so port 0 has first priority; all locks and `own_vld` cleared.
  - `match_end = 0`, `match_sram = 0`, `alloc_vld = 0`, `alloc_len = 0`, `sram_locked = 0`.
  - A scan in progress is discarded with no pulse.

## Timing
- All outputs are registered.
- Request sampled in IDLE at cycle t; SCAN step i, i = 0..31, runs in cycle t+1+i; a hit at step i produces `match_end` in cycle t+2+i.
- Minimum request-to-grant latency is 2 cycles; maximum is 33.
- A failed scan occupies 33 cycles: IDLE plus 32 SCAN cycles. The next IDLE decision is in cycle t+33.
- After DONE at cycle k, IDLE at k+1 masks the just-granted port, covering the frontend's one-cycle `match_enable` drop delay. Earliest next SCAN is k+2.
- `sram_locked` reflects a grant in the cycle after DONE, and a release in the cycle after the `release` pulse.
- Only one match is in flight at a time.

## Test plan
- **Single grant:** port 3 requests with dest 5, len 100, all `free_cnt = 2048`, no locks.
  - Required: `match_end = 16'h0008`, `match_sram = 10`, `alloc_len = 100`, at request cycle +2.
  - Then `sram_locked[10] = 1`.
- **Lock skip:** with SRAM 10 locked, port 4 requests dest 5 len 8.
  - Required: `match_sram = 11` at request cycle +3.
  - Then `release[3]` clears bit 10 one cycle later.
- **Round-robin:** ports 0, 1 and 15 request together from reset with all SRAMs free.
  - Required: grant order is 0, 1, 15, with one cycle in IDLE between grants.
- **Wrap:** dest 15 with SRAMs 30 and 31 locked, len 4.
  - Required: `match_sram = 0` at request cycle +4.
- **Capacity fail and retry:** `free_cnt` of every SRAM = 99, port 2 requests len 100.
  - Required: no `match_end` within 33 cycles, and port 2 is then re-arbitrated.
  - Raise SRAM 4's count to 100: grant with `match_sram = 4`, which is exactly equal to the length and therefore passes.
- **Reset mid-scan:** assert `rst_n = 0` during SCAN step 5.
  - Required: all outputs and `sram_locked` go to 0 immediately, and no `match_end` is issued.
  - After reset is released, the request is re-served starting from port 0 priority.

Source files
------------

// File: rtl/sram_match_arbiter.sv
`default_nettype none
// ============================================================================
// sram_match_arbiter : round-robin port arbiter feeding a first-fit SRAM scan
// Revision : 1.0
// ============================================================================
module sram_match_arbiter #(
    parameter int NUM_PORTS = 16,
    parameter int NUM_SRAMS = 32,
    parameter int FREE_W    = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        match_enable,
    input  logic [4*NUM_PORTS-1:0]      new_dest_port,
    input  logic [9*NUM_PORTS-1:0]      new_length,
    input  logic [FREE_W*NUM_SRAMS-1:0] free_cnt,
    input  logic [NUM_PORTS-1:0]        release_pulse,
    output logic [NUM_PORTS-1:0]        match_end,
    output logic [4:0]                  match_sram,
    output logic                        alloc_vld,
    output logic [8:0]                  alloc_len,
    output logic [NUM_SRAMS-1:0]        sram_locked
);
    localparam int PW = 4;
    localparam int SW = 5;
    localparam int LW = 9;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]        port_q, port_d;
    logic [LW-1:0]        len_q, len_d;
    logic [SW-1:0]        scan_idx_q, scan_idx_d;
    logic [SW-1:0]        scan_cnt_q, scan_cnt_d;
    logic                 mask_vld_q, mask_vld_d;
    logic [NUM_SRAMS-1:0] locked_q, locked_d;
    logic [NUM_PORTS-1:0] own_vld_q, own_vld_d;
    logic [SW-1:0]        owner_q [NUM_PORTS];
    logic [SW-1:0]        owner_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] match_end_q, match_end_d;
    logic [SW-1:0]        match_sram_q, match_sram_d;
    logic                 alloc_vld_q, alloc_vld_d;
    logic [LW-1:0]        alloc_len_q, alloc_len_d;

    logic [NUM_PORTS-1:0] w_pending;
    logic                 w_pick_vld;
    logic [PW-1:0]        w_pick;
    logic [FREE_W-1:0]    w_free_sel;
    logic                 w_hit;

    // The port granted in the previous DONE is hidden for one IDLE while its
    // frontend is still dropping match_enable.
    always_comb begin
        logic [PW-1:0] idx;
        idx        = '0;
        w_pending  = match_enable;
        if (mask_vld_q) begin
            w_pending[port_q] = 1'b0;
        end
        w_pick_vld = 1'b0;
        w_pick     = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = rr_ptr_q + PW'(i);
            if (!w_pick_vld && w_pending[idx]) begin
                w_pick_vld = 1'b1;
                w_pick     = idx;
            end
        end
    end

    always_comb begin
        w_free_sel = '0;
        for (int s = 0; s < NUM_SRAMS; s++) begin
            if (scan_idx_q == SW'(s)) begin
                w_free_sel = free_cnt[s*FREE_W +: FREE_W];
            end
        end
        w_hit = !locked_q[scan_idx_q] &&
                (w_free_sel >= {{(FREE_W-LW){1'b0}}, len_q});
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        port_d       = port_q;
        len_d        = len_q;
        scan_idx_d   = scan_idx_q;
        scan_cnt_d   = scan_cnt_q;
        mask_vld_d   = (state_q == DONE);
        locked_d     = locked_q;
        own_vld_d    = own_vld_q;
        owner_d      = owner_q;
        match_end_d  = '0;
        match_sram_d = '0;
        alloc_vld_d  = 1'b0;
        alloc_len_d  = '0;

        for (int p = 0; p < NUM_PORTS; p++) begin
            if (release_pulse[p] && own_vld_q[p]) begin
                locked_d[owner_q[p]] = 1'b0;
                own_vld_d[p]         = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (w_pick_vld) begin
                    port_d     = w_pick;
                    scan_cnt_d = '0;
                    state_d    = SCAN;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (w_pick == PW'(p)) begin
                            scan_idx_d = {new_dest_port[PW*p +: PW], 1'b0};
                            len_d      = new_length[LW*p +: LW];
                        end
                    end
                end
            end
            SCAN: begin
                if (w_hit) begin
                    state_d              = DONE;
                    match_end_d[port_q]  = 1'b1;
                    match_sram_d         = scan_idx_q;
                    alloc_vld_d          = 1'b1;
                    alloc_len_d          = len_q;
                end else if (scan_cnt_q == SW'(NUM_SRAMS-1)) begin
                    state_d  = IDLE;
                    rr_ptr_d = port_q;
                end else begin
                    scan_idx_d = scan_idx_q + SW'(1);
                    scan_cnt_d = scan_cnt_q + SW'(1);
                end
            end
            DONE: begin
                // A re-grant drops the port's previous lock before taking the new one.
                if (own_vld_q[port_q]) begin
                    locked_d[owner_q[port_q]] = 1'b0;
                end
                locked_d[scan_idx_q] = 1'b1;
                owner_d[port_q]      = scan_idx_q;
                own_vld_d[port_q]    = 1'b1;
                rr_ptr_d             = port_q;
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '1;
            port_q       <= '0;
            len_q        <= '0;
            scan_idx_q   <= '0;
            scan_cnt_q   <= '0;
            mask_vld_q   <= 1'b0;
            locked_q     <= '0;
            own_vld_q    <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                owner_q[p] <= '0;
            end
            match_end_q  <= '0;
            match_sram_q <= '0;
            alloc_vld_q  <= 1'b0;
            alloc_len_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            port_q       <= port_d;
            len_q        <= len_d;
            scan_idx_q   <= scan_idx_d;
            scan_cnt_q   <= scan_cnt_d;
            mask_vld_q   <= mask_vld_d;
            locked_q     <= locked_d;
            own_vld_q    <= own_vld_d;
            owner_q      <= owner_d;
            match_end_q  <= match_end_d;
            match_sram_q <= match_sram_d;
            alloc_vld_q  <= alloc_vld_d;
            alloc_len_q  <= alloc_len_d;
        end
    end

    assign match_end   = match_end_q;
    assign match_sram  = match_sram_q;
    assign alloc_vld   = alloc_vld_q;
    assign alloc_len   = alloc_len_q;
    assign sram_locked = locked_q;

endmodule
`default_nettype wire
